// File: rtl/replay_pkg.sv
// Shared types for the replay trace capture block.
// Holds the capture state encoding and the record layout helpers. A record is
// packed as {cycle stamp, data snapshot} with the snapshot in the low bits.
package replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned OVF_W = 16;
  localparam logic [OVF_W-1:0] OVF_MAX = 16'hFFFF;

  // Total record width: cycle field on top of the data field.
  function automatic int unsigned rec_width(int unsigned cycle_w, int unsigned data_w);
    return cycle_w + data_w;
  endfunction

  // Bit position where the cycle field starts (directly above the data field).
  function automatic int unsigned rec_cycle_lsb(int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/replay_trace_fifo.sv
// First-word fall-through record buffer for the trace capture block.
// Ports: clk/rst_n (async active-low), flush (synchronous empty), push/push_data,
// pop, head (oldest entry, valid when !empty), full, empty, count.
// The caller never pushes while full or pops while empty.
module replay_trace_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/replay_trace_capture.sv
// Trace capture for replay: stamps DUT samples with a cycle count, buffers them
// and streams them out over a valid/ready interface, then drains on request.
// Ports: clock, reset_n (async assert, synchronised release), enable (arm /
// return to idle), sample_valid/sample_data (DUT snapshot), stop_req (end
// capture), out_ready/out_valid/out_cycle/out_data/out_last (record stream),
// overflow_cnt (saturating dropped-sample count), done (trace complete).
module replay_trace_capture
  import replay_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CYCLE_W = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample_data,
  input  logic               stop_req,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [CYCLE_W-1:0] out_cycle,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic [15:0]        overflow_cnt,
  output logic               done
);

  localparam int unsigned REC_W   = rec_width(CYCLE_W, DATA_W);
  localparam int unsigned CYC_LSB = rec_cycle_lsb(DATA_W);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  state_t             state;
  state_t             state_next;
  logic [CYCLE_W-1:0] cycle_cnt;
  logic [REC_W-1:0]   head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               start;
  logic               capturing;
  logic               draining;
  logic               push;
  logic               drop;
  logic               pop;

  // Reset asserts asynchronously but releases two clock edges later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign start     = (state == ST_IDLE) && enable;
  assign capturing = (state == ST_CAPTURE);
  assign draining  = (state == ST_DRAIN);
  // Full is judged before any same-cycle pop, so a pop never rescues a push.
  assign push      = capturing && sample_valid && !full;
  assign drop      = capturing && sample_valid && full;
  assign pop       = out_valid && out_ready;

  // State register.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next state and stream/status decode.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;

    out_valid = (capturing || draining) && !empty;
    out_last  = draining && (count == CNT_W'(1));
    done      = (state == ST_DONE);

    case (state)
      ST_IDLE:    if (enable)   state_next = ST_CAPTURE;
      ST_CAPTURE: if (stop_req) state_next = ST_DRAIN;
      // Leave once the final record is accepted, or at once if nothing is left.
      ST_DRAIN:   if (empty || (out_last && out_ready)) state_next = ST_DONE;
      ST_DONE:    if (!enable)  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Cycle stamp and dropped-sample counter, both restarted on arming.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cycle_cnt    <= '0;
      overflow_cnt <= '0;
    end else if (start) begin
      cycle_cnt    <= '0;
      overflow_cnt <= '0;
    end else if (capturing) begin
      cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      if (drop && (overflow_cnt != OVF_MAX)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  replay_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (rst_int_n),
    .flush     (start),
    .push      (push),
    .push_data ({cycle_cnt, sample_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_cycle = head[CYC_LSB +: CYCLE_W];
  assign out_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_replay_trace_capture.sv
// Self-checking bench for replay_trace_capture: a 64-bit-stamp instance and a
// 4-bit-stamp instance share stimulus and are compared with a queue-based model.
module tb_replay_trace_capture;
  import replay_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n, enable, sample_valid, stop_req, out_ready;
  logic [63:0] sample_data;
  logic        out_valid, out_last, done;
  logic [63:0] out_cycle, out_data;
  logic [15:0] overflow_cnt;
  logic        v4, last4, done4;
  logic [3:0]  cyc4;
  logic [63:0] data4;
  logic [15:0] ovf4;

  replay_trace_capture #(.DATA_W(64), .DEPTH(DEPTH), .CYCLE_W(64)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .stop_req(stop_req), .out_ready(out_ready),
    .out_valid(out_valid), .out_cycle(out_cycle), .out_data(out_data),
    .out_last(out_last), .overflow_cnt(overflow_cnt), .done(done));

  replay_trace_capture #(.DATA_W(64), .DEPTH(DEPTH), .CYCLE_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .stop_req(stop_req), .out_ready(out_ready),
    .out_valid(v4), .out_cycle(cyc4), .out_data(data4),
    .out_last(last4), .overflow_cnt(ovf4), .done(done4));

  always #5 clock = ~clock;

  typedef enum int {M_IDLE, M_CAP, M_DRAIN, M_DONE} mphase_t;
  typedef struct { logic [63:0] cyc; logic [63:0] data; } rec_t;
  typedef struct { logic [63:0] cyc; logic [63:0] data; logic last; logic [3:0] cyc4; } obs_t;

  mphase_t     m_phase;
  rec_t        mq[$];
  logic [63:0] m_cyc;
  int          m_ovf;
  int          m_push_cnt;
  obs_t        obs_q[$];

  int valid_diff = 0, last_diff = 0, done_diff = 0, ovf_diff = 0, rec_diff = 0, stall_diff = 0;
  logic        prev_hold;
  logic [63:0] prev_cyc, prev_data;
  int n_checks = 0, n_fail = 0;

  task automatic model_reset();
    m_phase = M_IDLE; mq.delete(); m_cyc = '0; m_ovf = 0; prev_hold = 1'b0;
  endtask

  // One clock of stimulus; observes outputs against the model, then advances it.
  task automatic step(input logic sv, input logic [63:0] d, input logic stop,
                      input logic rdy, input logic en);
    logic exp_valid, exp_last, exp_done, was_full;
    rec_t hd;
    obs_t o;
    enable = en; sample_valid = sv; sample_data = d; stop_req = stop; out_ready = rdy;
    #1;
    exp_valid = (m_phase == M_CAP || m_phase == M_DRAIN) && (mq.size() != 0);
    exp_last  = (m_phase == M_DRAIN) && (mq.size() == 1);
    exp_done  = (m_phase == M_DONE);
    was_full  = (mq.size() == int'(DEPTH));
    if (out_valid !== exp_valid || v4 !== exp_valid) valid_diff++;
    if (out_last !== exp_last || last4 !== exp_last) last_diff++;
    if (done !== exp_done || done4 !== exp_done) done_diff++;
    if (overflow_cnt !== 16'(m_ovf) || ovf4 !== 16'(m_ovf)) ovf_diff++;
    if (prev_hold && out_valid === 1'b1 && (out_cycle !== prev_cyc || out_data !== prev_data))
      stall_diff++;
    prev_hold = (out_valid === 1'b1) && !rdy;
    prev_cyc  = out_cycle;
    prev_data = out_data;
    if (out_valid === 1'b1 && rdy) begin
      o.cyc = out_cycle; o.data = out_data; o.last = out_last; o.cyc4 = cyc4;
      obs_q.push_back(o);
    end
    if (exp_valid && rdy) begin
      hd = mq.pop_front();
      if (out_cycle !== hd.cyc || out_data !== hd.data || cyc4 !== hd.cyc[3:0] || data4 !== hd.data)
        rec_diff++;
    end
    case (m_phase)
      M_IDLE: if (en) begin m_phase = M_CAP; m_cyc = '0; m_ovf = 0; mq.delete(); end
      M_CAP: begin
        if (sv) begin
          if (was_full) begin if (m_ovf < 65535) m_ovf++; end
          else begin mq.push_back('{m_cyc, d}); m_push_cnt++; end
        end
        m_cyc = m_cyc + 64'd1;
        if (stop) m_phase = M_DRAIN;
      end
      M_DRAIN: if (mq.size() == 0) m_phase = M_DONE;
      default: if (!en) m_phase = M_IDLE;
    endcase
    @(negedge clock);
  endtask

  task automatic run_to_done(input int pct);
    for (int i = 0; i < 400 && m_phase != M_DONE; i++)
      step(1'b0, 64'd0, 1'b0, (int'($urandom_range(0, 99)) < pct), 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    stop_req = 1'b0; out_ready = 1'b0;
    @(negedge clock); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_overflow: got %0d expected 0", overflow_cnt); end
    n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(negedge clock);
    model_reset();
  endtask

  task automatic test_basic();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h10 + 64'(i), (i == 4), 1'b1, 1'b1);
    run_to_done(100);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b expected 1", done); end
    n_checks++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== 64'(i) || obs_q[i].data !== 64'h10 + 64'(i) || obs_q[i].last !== (i == 4)) begin
        n_fail++;
        $display("FAIL basic_rec%0d: got cyc=%0d data=%h last=%0b expected cyc=%0d data=%h last=%0b",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].last, i, 64'h10 + 64'(i), (i == 4));
      end
    end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, {$urandom, $urandom}, (i == 19), 1'b0, 1'b1);
    n_checks++; if (overflow_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", overflow_cnt); end
    run_to_done(60);
    n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL ovf_records: got %0d expected 16", obs_q.size()); end
    if (obs_q.size() == 16) begin
      n_checks++; if (obs_q[0].cyc !== 64'd0) begin n_fail++; $display("FAIL ovf_first: got %0d expected 0", obs_q[0].cyc); end
      n_checks++; if (obs_q[15].cyc !== 64'd15) begin n_fail++; $display("FAIL ovf_last_kept: got %0d expected 15", obs_q[15].cyc); end
    end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_empty_stop();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %0b expected 0", out_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_early: got %0b expected 0", done); end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %0b expected 1", done); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL empty_records: got %0d expected 0", obs_q.size()); end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full_pop();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b1);
    n_checks++; if (overflow_cnt !== 16'd1) begin n_fail++; $display("FAIL fullpop_ovf: got %0d expected 1", overflow_cnt); end
    n_checks++; if (dut.u_fifo.count !== 5'd15) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 15", dut.u_fifo.count); end
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    run_to_done(70);
    n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL fullpop_records: got %0d expected 16", obs_q.size()); end
    if (obs_q.size() == 16) begin
      n_checks++; if (obs_q[15].cyc !== 64'd15) begin n_fail++; $display("FAIL fullpop_tail: got %0d expected 15", obs_q[15].cyc); end
    end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_drain();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, (i == 2), 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstdrain_valid_before: got %0b expected 1", out_valid); end
    #2;
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; stop_req = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstdrain_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rstdrain_last: got %0b expected 0", out_last); end
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(negedge clock);
    model_reset();
    n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL rstdrain_state: got %0d expected %0d", dut.state, ST_IDLE); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstdrain_done: got %0b expected 0", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstdrain_valid_after: got %0b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    obs_q.delete();
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, {$urandom, $urandom}, (i == 19), 1'b1, 1'b1);
    run_to_done(100);
    n_checks++; if (obs_q.size() != 20) begin n_fail++; $display("FAIL wrap_records: got %0d expected 20", obs_q.size()); end
    if (obs_q.size() == 20) begin
      n_checks++; if (obs_q[15].cyc4 !== 4'hF) begin n_fail++; $display("FAIL wrap_c15: got %0d expected 15", obs_q[15].cyc4); end
      n_checks++; if (obs_q[16].cyc4 !== 4'h0) begin n_fail++; $display("FAIL wrap_c16: got %0d expected 0", obs_q[16].cyc4); end
      n_checks++; if (obs_q[16].cyc !== 64'd16) begin n_fail++; $display("FAIL wrap_wide16: got %0d expected 16", obs_q[16].cyc); end
    end
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      obs_q.delete();
      m_push_cnt = 0;
      // Stray sample/stop while idle must be ignored.
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      n = int'($urandom_range(10, 40));
      for (int i = 0; i < n; i++)
        step((int'($urandom_range(0, 99)) < 70), {$urandom, $urandom}, (i == n - 1), 1'($urandom_range(0, 1)), 1'b1);
      run_to_done(int'($urandom_range(30, 100)));
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got %0b expected 1", it, done); end
      n_checks++; if (obs_q.size() != m_push_cnt) begin n_fail++; $display("FAIL rand%0d_records: got %0d expected %0d", it, obs_q.size(), m_push_cnt); end
      for (int i = 0; i < 3; i++)
        step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_protocol();
    n_checks++; if (valid_diff != 0) begin n_fail++; $display("FAIL proto_out_valid: %0d cycles differ, expected 0", valid_diff); end
    n_checks++; if (last_diff != 0) begin n_fail++; $display("FAIL proto_out_last: %0d cycles differ, expected 0", last_diff); end
    n_checks++; if (done_diff != 0) begin n_fail++; $display("FAIL proto_done: %0d cycles differ, expected 0", done_diff); end
    n_checks++; if (ovf_diff != 0) begin n_fail++; $display("FAIL proto_overflow: %0d cycles differ, expected 0", ovf_diff); end
    n_checks++; if (rec_diff != 0) begin n_fail++; $display("FAIL proto_records: %0d records differ, expected 0", rec_diff); end
    n_checks++; if (stall_diff != 0) begin n_fail++; $display("FAIL proto_hold: %0d unstable stalls, expected 0", stall_diff); end
  endtask

  initial begin
    m_push_cnt = 0;
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_empty_stop();
    test_full_pop();
    test_reset_drain();
    test_wrap();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
